// File: rtl/addmul_sequencer_pkg.sv
// Shared constants for the shift-and-add multiplier: state encodings and default operand width.
// Builds with or without ADDMUL_ZERO_SKIP_EN; nothing in this file depends on it.
package addmul_sequencer_pkg;

    localparam int ADDMUL_SIZE_DEFAULT = 4;

    typedef enum logic [1:0] {
        ADDMUL_ST_IDLE    = 2'd0,
        ADDMUL_ST_RUN     = 2'd1,
        ADDMUL_ST_DONE    = 2'd2,
        ADDMUL_ST_ILLEGAL = 2'd3
    } addmul_state_e;

    function automatic int addmul_cnt_width(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/addmul_sequencer_adder.sv
// Plain SIZE-bit ripple-carry adder shared by the multiplier datapath.
// Builds identically with or without ADDMUL_ZERO_SKIP_EN.
module ADDER_N_BIT #(
    parameter int size = 4
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            cin,
    output logic [size-1:0] sum,
    output logic            cout
);

    always_comb begin : ripple
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < size; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/addmul_sequencer.sv
// Sequential unsigned multiplier: one shared-adder step per cycle for SIZE cycles.
// ADDMUL_ZERO_SKIP_EN: zero operands jump straight from IDLE to DONE with a zero product.
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// RUN   | one add/shift step per cycle, CNT counts down the remaining steps
// DONE  | product held on result, res_valid high until res_ready
module addmul_sequencer
    import addmul_sequencer_pkg::*;
#(
    parameter int SIZE = ADDMUL_SIZE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [SIZE-1:0]   in_a,
    input  logic [SIZE-1:0]   in_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*SIZE-1:0] result,
    output logic              busy
);

    localparam int CW = addmul_cnt_width(SIZE);

    addmul_state_e   state;
    logic [SIZE-1:0] m;
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] s;
    logic            c;

    ADDER_N_BIT #(.size(SIZE)) u_adder (
        .a    (hi),
        .b    (m),
        .cin  (1'b0),
        .sum  (s),
        .cout (c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ADDMUL_ST_IDLE;
            m     <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ADDMUL_ST_IDLE: begin
                    if (start_valid) begin
                        m  <= in_a;
                        hi <= '0;
                        lo <= in_b;
`ifdef ADDMUL_ZERO_SKIP_EN
                        if (in_a == '0 || in_b == '0) begin
                            lo    <= '0;
                            state <= ADDMUL_ST_DONE;
                        end else begin
                            cnt   <= CW'(SIZE);
                            state <= ADDMUL_ST_RUN;
                        end
`else
                        cnt   <= CW'(SIZE);
                        state <= ADDMUL_ST_RUN;
`endif
                    end
                end
                ADDMUL_ST_RUN: begin
                    // carry-out of HI+M becomes the new top bit; LO shifts the multiplier out
                    if (lo[0]) begin
                        {hi, lo} <= {c, s, lo[SIZE-1:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[SIZE-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ADDMUL_ST_DONE;
                    end
                end
                ADDMUL_ST_DONE: begin
                    if (res_ready) begin
                        state <= ADDMUL_ST_IDLE;
                    end
                end
                default: state <= ADDMUL_ST_IDLE;
            endcase
        end
    end

    assign start_ready = (state == ADDMUL_ST_IDLE);
    assign res_valid   = (state == ADDMUL_ST_DONE);
    assign busy        = (state == ADDMUL_ST_RUN) || (state == ADDMUL_ST_DONE);
    assign result      = {hi, lo};

endmodule

// File: tb/tb_addmul_sequencer.sv
// Self-checking bench for addmul_sequencer: directed cases, random operands with back-pressure,
// mid-run reset and a back-to-back stream; expectations come from plain a*b arithmetic.
module tb_addmul_sequencer;

    localparam int SIZE = 4;
    localparam int W    = 2 * SIZE;

    logic            clk;
    logic            rst_n;
    logic            start_valid;
    logic            start_ready;
    logic [SIZE-1:0] in_a;
    logic [SIZE-1:0] in_b;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    result;
    logic            busy;

    int checks = 0;
    int errors = 0;

    addmul_sequencer #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edges between the acceptance edge and the first cycle with res_valid high
    function automatic int exp_latency(input int a, input int b);
`ifdef ADDMUL_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 0;
`endif
        return SIZE;
    endfunction

    // Called at a negedge with the block in IDLE; returns -1 latency on timeout.
    task automatic run_op(input int a, input int b, output int lat, output logic [W-1:0] res);
        in_a        = SIZE'(a);
        in_b        = SIZE'(b);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) lat = -1;
        res = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({start_ready, res_valid, busy} !== 3'b100 || result !== '0) begin
            errors++;
            $display("FAIL reset: ready/valid/busy=%b result=%0d, required 100 and 0",
                     {start_ready, res_valid, busy}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b busy=%b, required 1 0", start_ready, busy);
        end
    endtask

    task automatic test_directed();
        int            lat;
        logic [W-1:0]  res;
        int            av[3] = '{13, 15, 0};
        int            bv[3] = '{11, 15, 9};
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], lat, res);
            checks++;
            if (res !== W'(av[i] * bv[i]) || lat !== exp_latency(av[i], bv[i])) begin
                errors++;
                $display("FAIL directed_%0dx%0d: result=%0d lat=%0d, required %0d lat=%0d",
                         av[i], bv[i], res, lat, av[i] * bv[i], exp_latency(av[i], bv[i]));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL directed_busy_in_done: busy=%b, required 1", busy);
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || start_ready !== 1'b1 || result !== W'(av[i] * bv[i])) begin
                errors++;
                $display("FAIL directed_after_handshake: valid=%b ready=%b result=%0d, required 0 1 %0d",
                         res_valid, start_ready, result, av[i] * bv[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [W-1:0] res;
        res_ready = 1'b0;
        run_op(7, 6, lat, res);
        checks++;
        if (res !== W'(42) || lat !== SIZE) begin
            errors++;
            $display("FAIL bp_result: result=%0d lat=%0d, required 42 lat=%0d", res, lat, SIZE);
        end
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            in_a        = SIZE'($urandom);
            in_b        = SIZE'($urandom);
            @(negedge clk);
            checks++;
            if (result !== W'(42) || res_valid !== 1'b1 || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: result=%0d valid=%b ready=%b, required 42 1 0",
                         i, result, res_valid, start_ready);
            end
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1 || result !== W'(42)) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b result=%0d, required 0 1 42",
                     res_valid, start_ready, result);
        end
    endtask

    task automatic test_random();
        int           a, b, lat, hold;
        logic [W-1:0] res;
        for (int n = 0; n < 25; n++) begin
            a    = int'($urandom_range(0, 15));
            b    = int'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 3));
            res_ready = (hold == 0);
            run_op(a, b, lat, res);
            checks++;
            if (res !== W'(a * b) || lat !== exp_latency(a, b)) begin
                errors++;
                $display("FAIL random_%0dx%0d: result=%0d lat=%0d, required %0d lat=%0d",
                         a, b, res, lat, a * b, exp_latency(a, b));
            end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++;
                if (result !== W'(a * b) || res_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL random_hold: result=%0d valid=%b, required %0d 1",
                             result, res_valid, a * b);
                end
            end
            if (hold != 0) begin
                res_ready = 1'b1;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            checks++;
            if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
                errors++;
                $display("FAIL random_return_idle: valid=%b ready=%b, required 0 1",
                         res_valid, start_ready);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int           lat;
        logic [W-1:0] res;
        res_ready   = 1'b1;
        in_a        = SIZE'(9);
        in_b        = SIZE'(9);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, res_valid, busy} !== 3'b100 || result !== '0) begin
            errors++;
            $display("FAIL midrun_reset: ready/valid/busy=%b result=%0d, required 100 and 0",
                     {start_ready, res_valid, busy}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3, 5, lat, res);
        checks++;
        if (res !== W'(15) || lat !== SIZE) begin
            errors++;
            $display("FAIL midrun_next_op: result=%0d lat=%0d, required 15 lat=%0d", res, lat, SIZE);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int           av[3] = '{1, 2, 15};
        int           bv[3] = '{1, 3, 1};
        int           got_val[$];
        int           got_cyc[$];
        int           idx = 0;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got_val.size() < 3; cyc++) begin
            if (res_valid) begin
                got_val.push_back(int'(result));
                got_cyc.push_back(cyc);
            end
            if (start_ready) begin
                if (idx < 3) begin
                    in_a        = SIZE'(av[idx]);
                    in_b        = SIZE'(bv[idx]);
                    start_valid = 1'b1;
                    idx++;
                end else begin
                    start_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        checks++;
        if (got_val.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count: results=%0d, required 3", got_val.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_val[i] !== av[i] * bv[i]) begin
                    errors++;
                    $display("FAIL b2b_value_%0d: result=%0d, required %0d", i, got_val[i], av[i] * bv[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (got_cyc[i] - got_cyc[i-1] !== SIZE + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: spacing=%0d, required %0d",
                             i, got_cyc[i] - got_cyc[i-1], SIZE + 2);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        in_a        = '0;
        in_b        = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
